// File: rtl/sop_scan_pkg.sv
// Shared types and constants for the SOP truth-table scanner.
package sop_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned TABLE_W = 16;
  localparam int unsigned ONES_W  = 5;

  // Reference truth tables of F = A(CD + B) + BC' with the enable high / low.
  localparam logic [TABLE_W-1:0] SOP_F_TABLE_E1 = 16'hF830;
  localparam logic [TABLE_W-1:0] SOP_F_TABLE_E0 = 16'h0000;

endpackage

// File: rtl/scan_settle_counter.sv
// Per-vector settle counter; tc_c flags the last settle cycle.
module scan_settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign tc_c = (cnt_q == TC_VAL);

endmodule

// File: rtl/sop_truth_table_scanner.sv
// Walks all 16 ABCD vectors through the SOP datapath, captures F into a
// truth table, counts the ones and compares against an expected table.
module sop_truth_table_scanner
  import sop_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               en_mode,
  input  logic [TABLE_W-1:0] exp_table,
  input  logic               f_in,
  output logic [VEC_W-1:0]   abcd_out,
  output logic               e_out,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_out,
  output logic [ONES_W-1:0]  ones_cnt,
  output logic               pass
);

  scan_state_e        state_q, state_d;
  logic [VEC_W-1:0]   abcd_d;
  logic               e_d, busy_d, done_d, pass_d;
  logic [TABLE_W-1:0] table_d;
  logic [ONES_W-1:0]  ones_d;
  logic               cnt_clr, cnt_en, cnt_tc_c;

  scan_settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (cnt_tc_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      abcd_out  <= '0;
      e_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      ones_cnt  <= '0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      abcd_out  <= abcd_d;
      e_out     <= e_d;
      busy      <= busy_d;
      done      <= done_d;
      table_out <= table_d;
      ones_cnt  <= ones_d;
      pass      <= pass_d;
    end
  end

  // Next state and next register values. pass is computed on the edge that
  // enters DONE, with the final sample merged in, so it is valid with done.
  always_comb begin
    state_d = state_q;
    abcd_d  = abcd_out;
    e_d     = e_out;
    table_d = table_out;
    ones_d  = ones_cnt;
    pass_d  = pass;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      IDLE: begin
        abcd_d = '0;
        e_d    = 1'b0;
        if (start) begin
          e_d     = en_mode;
          table_d = '0;
          ones_d  = '0;
          pass_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abcd_d  = '0;
          e_d     = 1'b0;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (cnt_tc_c) begin
          cnt_clr = 1'b1;
          state_d = SAMPLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          abcd_d  = '0;
          e_d     = 1'b0;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else begin
          table_d[abcd_out] = f_in;
          ones_d = ones_cnt + ONES_W'(f_in);
          if (&abcd_out) begin
            done_d  = 1'b1;
            pass_d  = (table_d == exp_table);
            state_d = DONE;
          end else begin
            abcd_d  = abcd_out + VEC_W'(1);
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        abcd_d  = '0;
        e_d     = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
  end

endmodule

// File: doc/sop_truth_table_scanner.md
Name: sop_truth_table_scanner

Overview:
- Sequencer for the 4-input SOP datapath F = A(CD + B) + BC'. That datapath is built from a positive-output, positive-enable 2x4 decoder and has inputs A, B, C, D and E.
- On `start`, it drives all 16 ABCD combinations in order (A = MSB) with a latched enable value, and waits a fixed settle time per vector.
- It samples F for each vector into a 16-bit truth-table register, counts the ones, and compares the result against an expected table.
- It sits between a lab-board control/debug front end and the combinational F datapath.

Parameters:
- `SETTLE_CYCLES`, default 2: cycles that each vector is held before F is sampled. Legal range 1..15.
- `CNT_W`, default 4: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: begin a scan. Sampled only in IDLE.
- `abort`, input, 1: cancel a scan in progress.
- `en_mode`, input, 1: enable value to apply for the whole scan. Latched at start.
- `exp_table`, input, 16: expected F per index. Sampled at the DONE transition.
- `f_in`, input, 1: F output from the datapath.
- `abcd_out`, output, 4: {A,B,C,D} driven to the datapath.
- `e_out`, output, 1: E driven to the datapath.
- `busy`, output, 1: high in SETTLE and SAMPLE.
- `done`, output, 1: one-cycle pulse when a scan completes.
- `table_out`, output, 16: captured F; bit i holds F at ABCD = i.
- `ones_cnt`, output, 5: number of 1s captured, 0..16.
- `pass`, output, 1: `table_out == exp_table`. Valid from `done` until the next start.

Behaviour:
- Reset (async, `rst` = 1): state = IDLE and every output is 0. This covers `abcd_out`, `e_out`, `busy`, `done`, `table_out`, `ones_cnt`, `pass` and the settle counter.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - `abcd_out` = 0 and `e_out` = 0.
  - If `start` = 1 at an edge, then at that edge: `e_out` <= `en_mode`, `abcd_out` <= 0, `table_out` <= 0, `ones_cnt` <= 0, `pass` <= 0, counter <= 0. Next state is SETTLE.
- SETTLE:
  - The counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, the counter clears and the next state is SAMPLE.
  - The vector is therefore stable for exactly SETTLE_CYCLES cycles before the sample.
- SAMPLE (one cycle):
  - `table_out[abcd_out]` <= `f_in` and `ones_cnt` <= `ones_cnt` + `f_in`.
  - If `abcd_out` == 15: next state is DONE and `abcd_out` is held at 15.
  - Otherwise: `abcd_out` <= `abcd_out` + 1 (4-bit, no wrap within a scan) and next state is SETTLE.
- DONE (one cycle):
  - `done` = 1 and `pass` <= (`table_out` == `exp_table`).
  - Next state is IDLE; `abcd_out` and `e_out` return to 0.
  - `table_out`, `ones_cnt` and `pass` hold until the next accepted start.
- Latency: `done` is high exactly 16*(SETTLE_CYCLES+1) cycles after the edge that accepted `start` (48 cycles at the default).
- `start` while busy or in DONE: ignored, with no restart or queueing.
- `abort`:
  - In SETTLE or SAMPLE: the next state is IDLE, with no `done` pulse and `pass` staying 0.
  - `table_out` and `ones_cnt` keep their partial contents.
  - If `abort` and `start` are both high in IDLE, `start` wins (`abort` is ignored outside busy).
  - If `abort` coincides with the final SAMPLE, `abort` wins: that sample is not written and no `done` is produced.
- `rst` mid-scan: immediate return to the reset values, independent of `clk`.
- `en_mode` changes during a scan have no effect; `e_out` stays at the latched value.
- `ones_cnt` is 5 bits so that a value of 16 does not overflow.

Decomposition:
- Shared package `sop_scan_pkg` holds:
  - the state encoding constants (IDLE = 0, SETTLE = 1, SAMPLE = 2, DONE = 3);
  - `SOP_F_TABLE_E1` = 16'hF830, the reference truth table with E = 1 (F = 1 at indices 4, 5, 11, 12, 13, 14, 15);
  - `SOP_F_TABLE_E0` = 16'h0000.
- One sub-module, `scan_settle_counter`, implements the settle counter: clear/enable inputs and a terminal-count output at SETTLE_CYCLES-1.

Test Plan:
- E = 1 full scan: `en_mode` = 1, `exp_table` = 16'hF830, `f_in` driven by the real F datapath, pulse `start` → `done` 48 cycles later, `table_out` = 16'hF830, `ones_cnt` = 7, `pass` = 1.
- E = 0 scan: `en_mode` = 0, `exp_table` = 16'h0000 → `table_out` = 16'h0000, `ones_cnt` = 0, `pass` = 1, and `e_out` = 0 throughout.
- Mismatch: `f_in` tied to 1, `exp_table` = 16'hF830 → `table_out` = 16'hFFFF, `ones_cnt` = 16, `pass` = 0.
- Abort: abort at ABCD = 6 → next cycle IDLE, `busy` = 0, no `done`; bits 0..5 hold the captured values and bits above are 0. A new `start` then clears the tables and completes normally.
- `start` while busy: a second `start` pulse at cycle 10 → single `done` at cycle 48 only, and `abcd_out` sequence 0..15 undisturbed.
- Async reset: `rst` pulsed mid-cycle at ABCD = 9 → all outputs 0 before the next clk edge; state IDLE.
